// File: rtl/phase_sequencer.sv
// Phase sequencer: generates the 3-bit instruction phase for the CPU Controller,
// with run / single-step / halt-resume control and a retired-instruction counter.
module phase_sequencer #(
  parameter int unsigned ICOUNT_W   = 16,
  parameter logic [2:0]  HALT_PHASE = 3'd4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                halt,
  input  logic                run,
  input  logic                step,
  input  logic                resume,
  output logic [2:0]          phase,
  output logic                running,
  output logic                halted,
  output logic                step_done,
  output logic [ICOUNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {StIdle, StRun, StStep, StHalted} state_e;

  state_e              state_q, state_d;
  logic [2:0]          phase_q, phase_d;
  logic [ICOUNT_W-1:0] count_q, count_d;
  logic                prev_step_q, prev_step_d;
  // Latched "run was dropped": the current instruction finishes, then IDLE.
  logic                stop_q, stop_d;
  logic                step_done_q, step_done_d;
  logic                running_q, running_d;
  logic                halted_q, halted_d;
  logic                advance;
  logic                eff_step;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    count_d     = count_q;
    prev_step_d = prev_step_q;
    stop_d      = stop_q;
    step_done_d = 1'b0;
    advance     = 1'b0;
    eff_step    = (state_q == StStep);

    unique case (state_q)
      StIdle: begin
        phase_d = 3'd0;
        stop_d  = 1'b0;
        if (run) begin
          state_d = StRun;
        end else if (step) begin
          state_d = StStep;
        end
      end
      StRun, StStep: begin
        if ((state_q == StRun) && !run) begin
          stop_d = 1'b1;
        end
        if (halt && (phase_q == HALT_PHASE)) begin
          state_d     = StHalted;
          prev_step_d = eff_step;
        end else begin
          advance = 1'b1;
        end
      end
      StHalted: begin
        if (resume) begin
          // Resume continues in the halted-from mode; phase_q == HALT_PHASE here.
          eff_step = prev_step_q;
          if (!prev_step_q && !run) begin
            stop_d = 1'b1;
          end
          advance = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Common phase advance; the 7->0 wrap retires the instruction.
    if (advance) begin
      phase_d = phase_q + 3'd1;
      state_d = eff_step ? StStep : StRun;
      if (phase_q == 3'd7) begin
        count_d = count_q + ICOUNT_W'(1);
        if (eff_step) begin
          state_d     = StIdle;
          step_done_d = 1'b1;
        end else if (stop_d) begin
          state_d = StIdle;
          stop_d  = 1'b0;
        end
      end
    end

    running_d = (state_d == StRun) || (state_d == StStep);
    halted_d  = (state_d == StHalted);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      phase_q     <= 3'd0;
      count_q     <= '0;
      prev_step_q <= 1'b0;
      stop_q      <= 1'b0;
      step_done_q <= 1'b0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      count_q     <= count_d;
      prev_step_q <= prev_step_d;
      stop_q      <= stop_d;
      step_done_q <= step_done_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
    end
  end

  assign phase       = phase_q;
  assign running     = running_q;
  assign halted      = halted_q;
  assign step_done   = step_done_q;
  assign instr_count = count_q;

endmodule
